// File: rtl/booth_mul_unit.sv
// Sequential radix-4 Booth multiplier: signed 32x32 -> 64 in 16 steps.
// Optional BOOTH_EARLY_TERM_EN finishes once the remaining multiplier digits are all zero.
module booth_mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_high,
    output logic [WIDTH-1:0] z_low
);

    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0] ONE = {{(PW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_nx;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   prod;
    logic [WIDTH:0]  mplier;
    logic [WIDTH:0]  mplier_sh;
    logic [3:0]      count;
    logic            early;
    logic            finish;

    assign mplier_sh = {{2{mplier[WIDTH]}}, mplier[WIDTH:2]};
    assign acc_nx    = acc + addend;
    assign finish    = (count == 4'd15) || early;

    always_comb begin
        addend = '0;
        unique case (mplier[2:0])
            3'b001, 3'b010: addend = mcand;
            3'b011:         addend = mcand << 1;
            3'b100:         addend = ~(mcand << 1) + ONE;
            3'b101, 3'b110: addend = ~mcand + ONE;
            default:        addend = '0;
        endcase
    end

`ifdef BOOTH_EARLY_TERM_EN
    // Set once the shifted multiplier is pure sign bits; every later digit is 0.
    logic term;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            term <= 1'b0;
        end else if (state == IDLE && start) begin
            term <= 1'b0;
        end else if (state == RUN) begin
            term <= (mplier_sh == '0) || (mplier_sh == '1);
        end
    end

    assign early = term;
`else
    assign early = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (finish) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            prod   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
                        mplier <= {multiplier, 1'b0};
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 2;
                    mplier <= mplier_sh;
                    count  <= count + 4'd1;
                    // Capture on the final step so the product is valid with done.
                    if (finish) prod <= acc_nx;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign z_high = prod[PW-1:WIDTH];
    assign z_low  = prod[WIDTH-1:0];

endmodule

// File: tb/tb_booth_mul_unit.sv
// Scoreboard bench for booth_mul_unit: products, latency, busy/ignore and reset.
module tb_booth_mul_unit;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        busy;
    logic        done;
    logic [31:0] z_high;
    logic [31:0] z_low;

    int checks = 0;
    int errors = 0;

`ifdef BOOTH_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [63:0] prod;
        int          lat;
    } exp_t;

    exp_t sb[$];

    booth_mul_unit #(.WIDTH(32)) dut (
        .Clock(Clock),
        .Resetn(Resetn),
        .start(start),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .busy(busy),
        .done(done),
        .z_high(z_high),
        .z_low(z_low)
    );

    always #5 Clock = ~Clock;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Edges from accept to the edge after which done is high.
    function automatic int model_lat(logic [31:0] b);
        logic [32:0] m;
        int          e;
        m = {b, 1'b0};
        e = 16;
        for (int s = 1; s <= 16; s++) begin
            m = {{2{m[32]}}, m[32:2]};
            if ((m == '0 || m == '1) && e == 16) e = (s < 16) ? s + 1 : 16;
        end
        return EARLY ? e : 16;
    endfunction

    task automatic issue(logic [31:0] a, logic [31:0] b);
        exp_t e;
        @(negedge Clock);
        start = 1'b1;
        multiplicand = a;
        multiplier = b;
        e.prod = longint'($signed(a)) * longint'($signed(b));
        e.lat = model_lat(b);
        sb.push_back(e);
        @(negedge Clock);
        start = 1'b0;
        multiplicand = $urandom;
        multiplier = $urandom;
        check("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_done(string tag, int elapsed);
        exp_t e;
        int   n;
        n = 0;
        for (int i = elapsed + 1; i <= 40; i++) begin
            @(negedge Clock);
            if (done) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            check({tag, "_timeout"}, {63'd0, done}, 64'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            check({tag, "_unexpected_done"}, {63'd0, done}, 64'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_lat"}, 64'(n), 64'(e.lat));
        check({tag, "_prod"}, {z_high, z_low}, e.prod);
        @(negedge Clock);
        check({tag, "_done_1cyc"}, {63'd0, done}, 64'd0);
        check({tag, "_hold"}, {z_high, z_low}, e.prod);
    endtask

    initial begin
        int cnt;
        repeat (2) @(negedge Clock);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_z", {z_high, z_low}, 64'd0);
        Resetn = 1'b1;

        issue(32'h22, 32'h24);
        wait_done("basic", 0);
        check("basic_const", {z_high, z_low}, 64'h4C8);

        issue(32'hFFFF_FFF9, 32'd5);
        wait_done("neg7x5", 0);
        check("neg7x5_const", {z_high, z_low}, 64'hFFFF_FFFF_FFFF_FFDD);

        issue(32'h8000_0000, 32'h8000_0000);
        wait_done("minxmin", 0);
        check("minxmin_const", {z_high, z_low}, 64'h4000_0000_0000_0000);

        issue(32'h7FFF_FFFF, 32'h8000_0000);
        wait_done("maxxmin", 0);
        check("maxxmin_const", {z_high, z_low}, 64'hC000_0000_8000_0000);

        // Second start mid-run must be dropped, not queued.
        issue(32'd1234, 32'hFFFF_FF00);
        repeat (4) @(negedge Clock);
        start = 1'b1;
        multiplicand = 32'd99;
        multiplier = 32'd77;
        @(negedge Clock);
        start = 1'b0;
        wait_done("ignore", 5);
        check("ignore_idle", {63'd0, busy}, 64'd0);
        issue(32'd99, 32'd77);
        wait_done("after_ignore", 0);

        // Reset in the middle of a run.
        issue(32'h1357_9BDF, 32'h2468_ACE0);
        repeat (7) @(negedge Clock);
        Resetn = 1'b0;
        @(negedge Clock);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_z", {z_high, z_low}, 64'd0);
        Resetn = 1'b1;
        sb.delete();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (done) cnt++;
        end
        check("midrst_no_done", 64'(cnt), 64'd0);
        issue(32'hDEAD_BEEF, 32'h0BAD_F00D);
        wait_done("post_rst", 0);

        issue(32'h1234_5678, 32'd0);
        wait_done("zero_mplier", 0);

        issue(32'h11, 32'd3);
        wait_done("three", 0);
        check("three_const", {z_high, z_low}, 64'h33);

        issue(32'h55, 32'hFFFF_FFFF);
        wait_done("minus_one", 0);

        for (int i = 0; i < 6; i++) begin
            issue($urandom, $urandom);
            wait_done("rand", 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
